// File: rtl/equiv_harness_pkg.sv
// Shared types and helpers for the equivalence stimulus/signature harness:
// FSM state enum, default LFSR taps / MISR polynomial, and the response fold.
package equiv_harness_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZERO  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Largest response and signature widths the fold helper supports.
  localparam int FOLD_MAX_IN    = 1024;
  localparam int FOLD_IN_IDX_W  = 10;
  localparam int FOLD_MAX_W     = 128;
  localparam int FOLD_IDX_W     = 7;

  // x^256 + x^254 + x^251 + x^246 + 1, expressed as a Fibonacci tap mask.
  localparam logic [255:0] DEF_STIM_TAPS = (256'h1 << 255) | (256'h1 << 253) |
                                           (256'h1 << 250) | (256'h1 << 245);
  localparam logic [63:0]  DEF_MISR_POLY = 64'h0000_0000_0000_001B;

  // Bit i of the zero-padded response lands in signature bit (i mod w).
  function automatic logic [FOLD_MAX_W-1:0] fold(input logic [FOLD_MAX_IN-1:0] data,
                                                 input int w);
    logic [FOLD_MAX_W-1:0] acc;
    logic [FOLD_IDX_W-1:0] idx;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_IN; i++) begin
      idx = FOLD_IDX_W'(i % w);
      acc[idx] = acc[idx] ^ data[FOLD_IN_IDX_W'(i)];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: folds each enabled response into a
// MISR_W-bit signature using a Galois-style feedback polynomial.
module misr_compactor
  import equiv_harness_pkg::*;
#(
  parameter int                OUT_W     = 552,
  parameter int                MISR_W    = 64,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [OUT_W-1:0]  data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_fold;
  logic [MISR_W-1:0] w_fb;

  assign w_fold = MISR_W'(fold(FOLD_MAX_IN'(data_i), MISR_W));
  assign w_fb   = r_sig[MISR_W-1] ? MISR_POLY : '0;

  // Signature register; clear wins over a coincident enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[MISR_W-2:0], 1'b0} ^ w_fb ^ w_fold;
    end else begin
      r_sig <= r_sig;
    end
  end

  assign sig_o = r_sig;

endmodule

// File: rtl/equiv_stim_misr.sv
// Stimulus/response harness: zero vector then NUM_VEC LFSR vectors, responses
// compacted by a MISR. Optional expect compare under EQUIV_EXPECT_CHECK_EN.
module equiv_stim_misr
  import equiv_harness_pkg::*;
#(
  parameter int                IN_W      = 256,
  parameter int                OUT_W     = 552,
  parameter int                NUM_VEC   = 20,
  parameter int                HOLD_CYC  = 1,
  parameter int                PIPE_LAT  = 0,
  parameter int                MISR_W    = 64,
  parameter logic [IN_W-1:0]   STIM_SEED = IN_W'(1'b1),
  parameter logic [IN_W-1:0]   STIM_TAPS = IN_W'(DEF_STIM_TAPS),
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic [IN_W-1:0]                stim_o,
  input  logic [OUT_W-1:0]               resp_i,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_VEC+2)-1:0]   vec_idx_o,
  output logic [MISR_W-1:0]              signature_o
`ifdef EQUIV_EXPECT_CHECK_EN
  ,
  input  logic [MISR_W-1:0]              expect_i,
  output logic                           pass_o,
  output logic                           fail_o
`endif
);

  localparam int IDX_W   = $clog2(NUM_VEC + 2);
  localparam int HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [IDX_W-1:0]   VEC_LAST   = IDX_W'(NUM_VEC);
  localparam logic [IN_W-1:0]    SEED_EFF   = (STIM_SEED == '0) ? IN_W'(1'b1) : STIM_SEED;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
    return {s[IN_W-2:0], ^(s & STIM_TAPS)};
  endfunction

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IN_W-1:0]    r_stim;
  logic [IN_W-1:0]    r_lfsr;
  logic [IDX_W-1:0]   r_vec_idx;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_busy;
  logic               r_done;
  logic               w_start_ok;
  logic               w_hold_last;
  logic               w_drain_last;
  logic               w_last_vec;
  logic               w_sample;
  logic               w_misr_en;
  logic [MISR_W-1:0]  w_sig;

  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_hold_last  = (r_hold_cnt == HOLD_LAST);
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
  assign w_last_vec   = (r_vec_idx == VEC_LAST);
  assign w_sample     = ((r_state == ZERO) || (r_state == RUN)) && w_hold_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ZERO; else w_state_nxt = IDLE;
      ZERO:    if (w_hold_last) w_state_nxt = RUN; else w_state_nxt = ZERO;
      RUN: begin
        if (w_hold_last && w_last_vec) begin
          w_state_nxt = (PIPE_LAT == 0) ? DONE : DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN:   if (w_drain_last) w_state_nxt = DONE; else w_state_nxt = DRAIN;
      DONE:    if (start) w_state_nxt = ZERO; else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Vector sequencing: LFSR advances as each vector is placed on stim_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim      <= '0;
      r_lfsr      <= SEED_EFF;
      r_vec_idx   <= '0;
      r_hold_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (w_start_ok) begin
      r_stim      <= '0;
      r_lfsr      <= SEED_EFF;
      r_vec_idx   <= '0;
      r_hold_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ZERO, RUN: begin
          if (w_hold_last) begin
            r_hold_cnt <= '0;
            if (!((r_state == RUN) && w_last_vec)) begin
              r_stim    <= r_lfsr;
              r_lfsr    <= lfsr_step(r_lfsr);
              r_vec_idx <= r_vec_idx + IDX_W'(1);
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        DRAIN:   r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        default: r_drain_cnt <= r_drain_cnt;
      endcase
    end
  end

  // Status flags follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ZERO) || (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done <= (w_state_nxt == DONE);
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign w_misr_en = w_sample;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] r_pipe;
      // Delays each sample strobe to line up with the DUT's response latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else if (w_start_ok) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= PIPE_LAT'({r_pipe, w_sample});
        end
      end
      assign w_misr_en = r_pipe[PIPE_LAT-1];
    end
  endgenerate

  misr_compactor #(
    .OUT_W     (OUT_W),
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_start_ok),
    .en     (w_misr_en),
    .data_i (resp_i),
    .sig_o  (w_sig)
  );

  assign stim_o      = r_stim;
  assign busy        = r_busy;
  assign done        = r_done;
  assign vec_idx_o   = r_vec_idx;
  assign signature_o = w_sig;

`ifdef EQUIV_EXPECT_CHECK_EN
  logic r_chk_pend;
  logic r_pass;
  logic r_fail;

  // The final MISR update lands on the DONE entry edge, so compare one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_pend <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else if (w_start_ok) begin
      r_chk_pend <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else if (r_chk_pend) begin
      r_chk_pend <= 1'b0;
      r_pass     <= (w_sig == expect_i);
      r_fail     <= (w_sig != expect_i);
    end else begin
      r_chk_pend <= (r_state != DONE) && (w_state_nxt == DONE);
      r_pass     <= r_pass;
      r_fail     <= r_fail;
    end
  end

  assign pass_o = r_pass;
  assign fail_o = r_fail;
`endif

endmodule

// File: tb/tb_equiv_stim_misr.sv
// Directed bench for equiv_stim_misr: two instances (HOLD=1/PIPE=0 and
// HOLD=3/PIPE=2), hand-computed stimulus sequences and signatures.
module tb_equiv_stim_misr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [11:0] resp_a = 12'h000, resp_b = 12'h000;
  logic [7:0]  stim_a, stim_b, sig_a, sig_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [2:0]  idx_a, idx_b;
  int          n_tests = 0;
  int          n_fail = 0;
`ifdef EQUIV_EXPECT_CHECK_EN
  logic [7:0]  expect_a = 8'h00, expect_b = 8'h00;
  logic        pass_a, fail_a, pass_b, fail_b;
`endif

  always #5 clk = ~clk;

  equiv_stim_misr #(
    .IN_W(8), .OUT_W(12), .NUM_VEC(3), .HOLD_CYC(1), .PIPE_LAT(0), .MISR_W(8),
    .STIM_SEED(8'h01), .STIM_TAPS(8'hB8), .MISR_POLY(8'h1D)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim_o(stim_a), .resp_i(resp_a),
    .busy(busy_a), .done(done_a), .vec_idx_o(idx_a), .signature_o(sig_a)
`ifdef EQUIV_EXPECT_CHECK_EN
    , .expect_i(expect_a), .pass_o(pass_a), .fail_o(fail_a)
`endif
  );

  equiv_stim_misr #(
    .IN_W(8), .OUT_W(12), .NUM_VEC(3), .HOLD_CYC(3), .PIPE_LAT(2), .MISR_W(8),
    .STIM_SEED(8'h01), .STIM_TAPS(8'hB8), .MISR_POLY(8'h1D)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim_o(stim_b), .resp_i(resp_b),
    .busy(busy_b), .done(done_b), .vec_idx_o(idx_b), .signature_o(sig_b)
`ifdef EQUIV_EXPECT_CHECK_EN
    , .expect_i(expect_b), .pass_o(pass_b), .fail_o(fail_b)
`endif
  );

  // Expected u_a outputs at the negedge after start edge E0..E4, resp_i = 1.
  logic [7:0] t1_stim [5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h04};
  logic [2:0] t1_idx  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
  logic       t1_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t1_done [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] t1_sig  [5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic run_a(input logic [11:0] resp);
    resp_a = resp;
    pulse_start_a();
    for (int k = 0; k < 20 && done_a !== 1'b1; k++) @(negedge clk);
    n_tests++;
    if (done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL run_a_done: done=%b, required 1 within 20 cycles", done_a);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({stim_a, busy_a, done_a, idx_a, sig_a} !== {8'h00, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_a: stim=%h busy=%b done=%b idx=%0d sig=%h, required all 0",
               stim_a, busy_a, done_a, idx_a, sig_a);
    end
    n_tests++;
    if ({stim_b, busy_b, done_b, idx_b, sig_b} !== {8'h00, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_b: stim=%h busy=%b done=%b idx=%0d sig=%h, required all 0",
               stim_b, busy_b, done_b, idx_b, sig_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stim_seq();
    resp_a = 12'h001;
    pulse_start_a();
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      n_tests++;
      if ({stim_a, idx_a, busy_a, done_a, sig_a} !==
          {t1_stim[n], t1_idx[n], t1_busy[n], t1_done[n], t1_sig[n]}) begin
        n_fail++;
        $display("FAIL t1_seq n=%0d: stim=%h idx=%0d busy=%b done=%b sig=%h, required %h %0d %b %b %h",
                 n, stim_a, idx_a, busy_a, done_a, sig_a,
                 t1_stim[n], t1_idx[n], t1_busy[n], t1_done[n], t1_sig[n]);
      end
    end
  endtask

  task automatic test_signature();
    run_a(12'h000);
    n_tests++;
    if (sig_a !== 8'h00) begin
      n_fail++;
      $display("FAIL sig_zero_resp: sig=%h, required 00", sig_a);
    end
    run_a(12'h080);
    n_tests++;
    if (sig_a !== 8'hD3) begin
      n_fail++;
      $display("FAIL sig_poly_fb: sig=%h, required d3", sig_a);
    end
    run_a(12'hA53);
    n_tests++;
    if (sig_a !== 8'h60) begin
      n_fail++;
      $display("FAIL sig_fold: sig=%h, required 60", sig_a);
    end
  endtask

  task automatic test_pipeline();
    logic [7:0] es, ex_stim;
    logic [2:0] ei;
    int         changes;
    logic [7:0] prev;
    changes = 0;
    prev    = sig_b;
    resp_b  = 12'h001;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      es      = (n >= 14) ? 8'h0F : (n >= 11) ? 8'h07 : (n >= 8) ? 8'h03 : (n >= 5) ? 8'h01 : 8'h00;
      ex_stim = (n >= 9) ? 8'h04 : (n >= 6) ? 8'h02 : (n >= 3) ? 8'h01 : 8'h00;
      ei      = (n >= 9) ? 3'd3 : (n >= 6) ? 3'd2 : (n >= 3) ? 3'd1 : 3'd0;
      if (sig_b !== prev) changes++;
      prev = sig_b;
      n_tests++;
      if ({stim_b, idx_b, sig_b, done_b, busy_b} !== {ex_stim, ei, es, (n >= 14), (n < 14)}) begin
        n_fail++;
        $display("FAIL t3_pipe n=%0d: stim=%h idx=%0d sig=%h done=%b busy=%b, required %h %0d %h %b %b",
                 n, stim_b, idx_b, sig_b, done_b, busy_b, ex_stim, ei, es, (n >= 14), (n < 14));
      end
    end
    n_tests++;
    if (changes != 4) begin
      n_fail++;
      $display("FAIL t3_enable_count: %0d signature updates, required 4", changes);
    end
  endtask

  task automatic test_start_busy_and_reset();
    resp_a = 12'h001;
    pulse_start_a();
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      n_tests++;
      if ({stim_a, idx_a, busy_a, done_a, sig_a} !==
          {t1_stim[n], t1_idx[n], t1_busy[n], t1_done[n], t1_sig[n]}) begin
        n_fail++;
        $display("FAIL t4_start_busy n=%0d: stim=%h idx=%0d busy=%b done=%b sig=%h, required %h %0d %b %b %h",
                 n, stim_a, idx_a, busy_a, done_a, sig_a,
                 t1_stim[n], t1_idx[n], t1_busy[n], t1_done[n], t1_sig[n]);
      end
      start_a = (n == 1) ? 1'b1 : 1'b0;
    end
    pulse_start_a();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({stim_a, busy_a, done_a, idx_a, sig_a} !== {8'h00, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL t4_async_reset: stim=%h busy=%b done=%b idx=%0d sig=%h, required all 0",
               stim_a, busy_a, done_a, idx_a, sig_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_tests++;
      if ({stim_a, busy_a, done_a, idx_a, sig_a} !== {8'h00, 1'b0, 1'b0, 3'd0, 8'h00}) begin
        n_fail++;
        $display("FAIL t4_idle_after_reset n=%0d: stim=%h busy=%b done=%b idx=%0d sig=%h, required all 0",
                 n, stim_a, busy_a, done_a, idx_a, sig_a);
      end
    end
    run_a(12'h001);
    n_tests++;
    if (sig_a !== 8'h0F) begin
      n_fail++;
      $display("FAIL t4_rerun_sig: sig=%h, required 0f", sig_a);
    end
  endtask

`ifdef EQUIV_EXPECT_CHECK_EN
  task automatic test_expect_check();
    expect_a = 8'h0F;
    run_a(12'h001);
    @(negedge clk);
    n_tests++;
    if ({pass_a, fail_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL t5_pass: pass=%b fail=%b, required 1 0", pass_a, fail_a);
    end
    expect_a = 8'h0E;
    pulse_start_a();
    n_tests++;
    if ({pass_a, fail_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL t5_clear_on_start: pass=%b fail=%b, required 0 0", pass_a, fail_a);
    end
    for (int k = 0; k < 20 && done_a !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({pass_a, fail_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL t5_fail: pass=%b fail=%b, required 0 1", pass_a, fail_a);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] first_sig;
    run_a(12'hA53);
    first_sig = sig_a;
    n_tests++;
    if (first_sig !== 8'h60) begin
      n_fail++;
      $display("FAIL t6_first_sig: sig=%h, required 60", first_sig);
    end
    pulse_start_a();
    n_tests++;
    if ({stim_a, idx_a, busy_a, done_a, sig_a} !== {8'h00, 3'd0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL t6_restart: stim=%h idx=%0d busy=%b done=%b sig=%h, required 00 0 1 0 00",
               stim_a, idx_a, busy_a, done_a, sig_a);
    end
    for (int k = 0; k < 20 && done_a !== 1'b1; k++) @(negedge clk);
    n_tests++;
    if ({done_a, sig_a} !== {1'b1, first_sig}) begin
      n_fail++;
      $display("FAIL t6_second_sig: done=%b sig=%h, required 1 %h", done_a, sig_a, first_sig);
    end
  endtask

  initial begin
    test_reset();
    test_stim_seq();
    test_signature();
    test_pipeline();
    test_start_busy_and_reset();
`ifdef EQUIV_EXPECT_CHECK_EN
    test_expect_check();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
